// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store stage and data_mem_ctrl.
// The master issues valid/ready requests; the slave answers with a one-cycle response pulse.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory with byte-lane writes, out-of-range error responses and a
// zero-fill engine that runs after reset and on a soft clear.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_INIT  | zero-fill engine writes 0 to mem[ptr] each cycle; no requests
// S_READY | requests accepted (unless clear); clear restarts S_INIT at 0
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  data_mem_ctrl_if.slave   bus,
  output logic             init_busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable and never flags an error.
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign bus.req_ready = (state == S_READY) && !clear;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = ({1'b0, bus.req_addr} < DEPTH_LIM);
  assign req_idx       = bus.req_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_INIT;
      ptr           <= '0;
      init_busy     <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= accept;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      if (accept) begin
        bus.rsp_err <= !in_range;
        if (!bus.req_we && in_range) begin
          bus.rsp_rdata <= mem[req_idx];
        end
      end

      case (state)
        S_INIT: begin
          if (ptr == LAST_IDX) begin
            state     <= S_READY;
            init_busy <= 1'b0;
            ptr       <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_READY: begin
          if (clear) begin
            state     <= S_INIT;
            init_busy <= 1'b1;
            ptr       <= '0;
          end
        end
        default: begin
          state     <= S_INIT;
          init_busy <= 1'b1;
          ptr       <= '0;
        end
      endcase
    end
  end

  // Storage has no reset; the zero-fill engine is what clears it.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[ptr] <= '0;
    end else if (accept && bus.req_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) begin
          mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: an 8-bit/33-word instance and a 16-bit/16-word
// instance (full address space) checked against a word-array reference model.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear8 = 1'b0;
  logic clear16 = 1'b0;
  logic init_busy8, init_busy16;

  int n_tests = 0;
  int n_fail = 0;

  data_mem_ctrl_if #(.DATA_W(8),  .ADDR_W(8)) b8 ();
  data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(4)) b16 ();

  data_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(33)) u_dut8 (
    .clk(clk), .reset(reset), .clear(clear8), .bus(b8), .init_busy(init_busy8));

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .clear(clear16), .bus(b16), .init_busy(init_busy16));

  always #5 clk = ~clk;

  // Reference model: word arrays plus "cycles of zero-fill remaining".
  logic [7:0]  m8  [33];
  logic [15:0] m16 [16];
  int busy8, busy16;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy8  <= 33;
      busy16 <= 16;
    end else begin
      busy8  <= (busy8  > 0) ? busy8  - 1 : (clear8  ? 33 : 0);
      busy16 <= (busy16 > 0) ? busy16 - 1 : (clear16 ? 16 : 0);
    end
  end

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         be;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    b8.req_valid = 0; b8.req_we = 0; b8.req_addr = '0; b8.req_wdata = '0; b8.req_be = '0;
    b16.req_valid = 0; b16.req_we = 0; b16.req_addr = '0; b16.req_wdata = '0; b16.req_be = '0;
    clear8 = 0; clear16 = 0;
  endtask

  task automatic zero_models();
    foreach (m8[i])  m8[i]  = '0;
    foreach (m16[i]) m16[i] = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the response checked.
  task automatic cyc8(input bit v, input bit we, input logic [7:0] a,
                      input logic [7:0] d, input bit be, input bit clr);
    bit acc, e_err;
    logic [7:0] e_data;
    b8.req_valid = v; b8.req_we = we; b8.req_addr = a; b8.req_wdata = d; b8.req_be = be;
    clear8 = clr;
    #1;
    chk("ready8", b8.req_ready, (busy8 == 0) && !clr);
    chk("busy8", init_busy8, busy8 != 0);
    acc = v && (busy8 == 0) && !clr;
    e_err = acc && (a >= 33);
    e_data = (acc && !we && a < 33) ? m8[a] : 8'h00;
    if (acc && we && a < 33 && be) m8[a] = d;
    if (busy8 == 0 && clr) foreach (m8[i]) m8[i] = '0;
    @(posedge clk); #1;
    b8.req_valid = 0; clear8 = 0;
    chk("rsp_valid8", b8.rsp_valid, acc);
    chk("rsp_rdata8", b8.rsp_rdata, e_data);
    chk("rsp_err8", b8.rsp_err, e_err);
  endtask

  task automatic cyc16(input bit v, input bit we, input logic [3:0] a,
                       input logic [15:0] d, input logic [1:0] be, input bit clr);
    bit acc;
    logic [15:0] e_data;
    b16.req_valid = v; b16.req_we = we; b16.req_addr = a; b16.req_wdata = d; b16.req_be = be;
    clear16 = clr;
    #1;
    chk("ready16", b16.req_ready, (busy16 == 0) && !clr);
    chk("busy16", init_busy16, busy16 != 0);
    acc = v && (busy16 == 0) && !clr;
    e_data = (acc && !we) ? m16[a] : 16'h0000;
    if (acc && we) begin
      for (int i = 0; i < 2; i++) if (be[i]) m16[a][8*i +: 8] = d[8*i +: 8];
    end
    if (busy16 == 0 && clr) foreach (m16[i]) m16[i] = '0;
    @(posedge clk); #1;
    b16.req_valid = 0; clear16 = 0;
    chk("rsp_valid16", b16.rsp_valid, acc);
    chk("rsp_rdata16", b16.rsp_rdata, e_data);
    chk("rsp_err16", b16.rsp_err, 1'b0);
  endtask

  // Counts busy samples from reset release; leaves at posedge+1 with both idle.
  task automatic measure_init();
    int n8, n16;
    n8 = 0; n16 = 0;
    for (int k = 0; k < 100; k++) begin
      if (init_busy8) begin
        n8++;
        chk("ready8_in_init", b8.req_ready, 1'b0);
      end
      if (init_busy16) n16++;
      if (!init_busy8 && !init_busy16) break;
      @(posedge clk); #1;
    end
    chk("init_len8", n8, 33);
    chk("init_len16", n16, 16);
    chk("ready8_after_init", b8.req_ready, 1'b1);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid8", b8.rsp_valid, 1'b0);
    chk("rst_busy8", init_busy8, 1'b1);
    chk("rst_ready8", b8.req_ready, 1'b0);
    reset = 1;
    zero_models();
  endtask

  initial begin
    tbl[0]  = '{1, 8'd5,   8'hA5, 1, 8'h00, 0};
    tbl[1]  = '{0, 8'd5,   8'h00, 0, 8'hA5, 0};
    tbl[2]  = '{0, 8'd33,  8'h00, 0, 8'h00, 1};
    tbl[3]  = '{1, 8'd200, 8'hFF, 1, 8'h00, 1};
    tbl[4]  = '{0, 8'd32,  8'h00, 0, 8'h00, 0};
    tbl[5]  = '{1, 8'd32,  8'h3C, 1, 8'h00, 0};
    tbl[6]  = '{0, 8'd32,  8'h00, 0, 8'h3C, 0};
    tbl[7]  = '{1, 8'd32,  8'hFF, 0, 8'h00, 0};
    tbl[8]  = '{0, 8'd32,  8'h00, 0, 8'h3C, 0};
    tbl[9]  = '{0, 8'd255, 8'h00, 0, 8'h00, 1};
    tbl[10] = '{0, 8'd0,   8'h00, 0, 8'h00, 0};

    idle_inputs();
    zero_models();
    #1;
    do_reset();
    measure_init();

    // All words read zero after init.
    for (int a = 0; a < 33; a++) cyc8(1, 0, 8'(a), 8'h00, 0, 0);

    // Back-to-back vector table, including out-of-range and be=0 cases.
    foreach (tbl[i]) begin
      cyc8(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0);
      chk("tbl_rdata", b8.rsp_rdata, tbl[i].exp_rdata);
      chk("tbl_err", b8.rsp_err, tbl[i].exp_err);
    end
    for (int a = 0; a < 33; a++) cyc8(1, 0, 8'(a), 8'h00, 0, 0);

    // Partial byte-lane writes on the 16-bit instance.
    cyc16(1, 1, 4'd3, 16'h1234, 2'b11, 0);
    cyc16(1, 1, 4'd3, 16'hABCD, 2'b01, 0);
    cyc16(1, 0, 4'd3, 16'h0000, 2'b00, 0);
    chk("lane_merge", b16.rsp_rdata, 16'h12CD);
    cyc16(1, 1, 4'd3, 16'hFFFF, 2'b00, 0);
    cyc16(1, 0, 4'd3, 16'h0000, 2'b00, 0);
    chk("be0_nochange", b16.rsp_rdata, 16'h12CD);
    cyc16(1, 0, 4'd15, 16'h0000, 2'b00, 0);
    chk("full_space_no_err", b16.rsp_err, 1'b0);

    // Clear with a same-cycle request; the preceding read still responds.
    cyc8(1, 1, 8'd9, 8'h5A, 1, 0);
    cyc8(1, 0, 8'd9, 8'h00, 0, 0);
    chk("pre_clear_read", b8.rsp_rdata, 8'h5A);
    cyc8(1, 1, 8'd9, 8'hEE, 1, 1);
    for (int k = 0; k < 33; k++) cyc8(0, 0, 8'd0, 8'h00, 0, k == 5);
    chk("ready_after_clear", b8.req_ready, 1'b1);
    for (int a = 0; a < 33; a++) cyc8(1, 0, 8'(a), 8'h00, 0, 0);

    // Reset in the middle of INIT (ptr=10).
    do_reset();
    repeat (10) begin @(posedge clk); #1; end
    #2 reset = 0;
    #1;
    chk("midinit_busy", init_busy8, 1'b1);
    chk("midinit_ready", b8.req_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1;
    zero_models();
    measure_init();

    // Reset with a read response pending drops it without a clock edge.
    cyc8(1, 1, 8'd7, 8'h77, 1, 0);
    b8.req_valid = 1; b8.req_we = 0; b8.req_addr = 8'd7;
    @(posedge clk); #1;
    b8.req_valid = 0;
    chk("pend_valid", b8.rsp_valid, 1'b1);
    chk("pend_rdata", b8.rsp_rdata, 8'h77);
    #2 reset = 0;
    #1;
    chk("async_valid", b8.rsp_valid, 1'b0);
    chk("async_rdata", b8.rsp_rdata, 8'h00);
    chk("async_err", b8.rsp_err, 1'b0);
    chk("async_busy", init_busy8, 1'b1);
    @(posedge clk); #1;
    reset = 1;
    zero_models();
    measure_init();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc8($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
           ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(39, 0)),
           8'($urandom), $urandom_range(3, 0) != 0, $urandom_range(60, 0) == 0);
    end
    for (int k = 0; k < 300; k++) begin
      cyc16($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, 4'($urandom_range(15, 0)),
            16'($urandom), 2'($urandom_range(3, 0)), $urandom_range(60, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data memory for the CPU datapath with a valid/ready request port and a registered response port. Adds per-byte write enables, out-of-range error reporting, and a hardware init/clear engine. The engine zeroes the array one word per cycle after reset and on a soft clear request, so no reset fan-out to the storage array is needed. It sits between the load/store stage and data storage.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of 8.
ADDR_W, 8, request address width.
DEPTH, 33, number of words; DEPTH <= 2**ADDR_W.
BE_W, DATA_W/8, byte-lane count (derived, not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
clear  in  1  soft-clear request pulse; restarts the init engine
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  BE_W  byte-lane write enables; bit i covers bits [8i+7:8i]
rsp_valid  out  1  one-cycle pulse per accepted request
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  address out of range, valid with rsp_valid
init_busy  out  1  init/clear engine running

Behaviour:
- States: INIT, READY.
- Reset asserted (reset=0): asynchronously force state=INIT, clear pointer=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1. Array contents are not reset directly.
- INIT: each cycle write 0 to mem[ptr] and increment ptr. When ptr==DEPTH-1 is written, go to READY next cycle. INIT lasts exactly DEPTH cycles after reset release.
- In INIT: init_busy=1 and req_ready=0. clear is ignored in INIT and does not restart the pointer.
- READY: init_busy=0 and req_ready = !clear (combinational).
- clear=1 in READY: go to INIT with ptr=0. A same-cycle request is not accepted.
- Accepted request, addr < DEPTH:
  - Write: update each lane i with req_be[i]=1 at that edge; other lanes unchanged. Next cycle: rsp_valid=1, rsp_rdata=0, rsp_err=0.
  - Read: next cycle rsp_valid=1, rsp_rdata=mem[addr], rsp_err=0. Latency is exactly 1 cycle.
- Accepted request, addr >= DEPTH: no array access. Next cycle rsp_valid=1, rsp_rdata=0, rsp_err=1.
- req_be=0 write: legal, no change, normal response.
- Throughput: one request per cycle, back-to-back. A read immediately after a write to the same address returns the new data.
- No response backpressure; rsp_valid is high only in the cycle after acceptance, otherwise 0. rsp_rdata and rsp_err return to 0 when rsp_valid=0.
- A request accepted in the cycle before clear still produces its response in the following cycle. That response is not cancelled by the state change.
- Reset mid-INIT or mid-stream: pending response is dropped immediately, and INIT restarts from ptr=0 for the full DEPTH cycles.
- Address comparison is unsigned at full ADDR_W. With DEPTH == 2**ADDR_W, rsp_err is never set.

Test Plan:
1. Defaults; hold reset=0 for 3 cycles, then release -> init_busy=1 and req_ready=0 for exactly 33 cycles, then req_ready=1. Reads of addr 0..32 all return rsp_rdata=0x00, rsp_err=0.
2. Write 0xA5 to addr 5 (be=1), read addr 5 in the next cycle back-to-back -> read rsp_valid one cycle after acceptance with rsp_rdata=0xA5. Write response shows rsp_rdata=0x00.
3. Read addr 33 -> rsp_err=1, rsp_rdata=0x00. Write 0xFF to addr 200 -> rsp_err=1; full readback of 0..32 is unchanged.
4. DATA_W=16: write 0x1234 be=2'b11 to addr 3, then 0xABCD be=2'b01 to addr 3, then read addr 3 -> rsp_rdata=0x12CD. A be=2'b00 write leaves 0x12CD.
5. After writing nonzero data, pulse clear with req_valid=1 in the same cycle -> request not accepted, init_busy high for 33 cycles, all words read back 0x00.
6. Assert reset=0 mid-INIT (ptr=10) and again during a read with a pending response -> rsp_valid, rsp_rdata, rsp_err go 0 without waiting for clk. INIT restarts and runs the full 33 cycles.
